// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory burst port between IC and DC refill engines
module mem_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 22,
    parameter int BURST_LEN     = 4
) (
    input  logic                     i_Clk,
    input  logic                     i_Reset,
    input  logic                     i_IC_MEM_Valid,
    input  logic [ADDRESS_WIDTH-1:0] i_IC_MEM_Address,
    output logic                     o_IC_MEM_Valid,
    output logic                     o_IC_MEM_Last,
    output logic [DATA_WIDTH-1:0]    o_IC_MEM_Data,
    input  logic                     i_DC_MEM_Valid,
    input  logic                     i_DC_MEM_Write,
    input  logic [ADDRESS_WIDTH-1:0] i_DC_MEM_Address,
    input  logic [DATA_WIDTH-1:0]    i_DC_MEM_Data,
    output logic                     o_DC_MEM_Valid,
    output logic                     o_DC_MEM_Last,
    output logic [DATA_WIDTH-1:0]    o_DC_MEM_Data,
    output logic                     o_MEM_Valid,
    output logic                     o_MEM_Write,
    output logic [ADDRESS_WIDTH-1:0] o_MEM_Address,
    output logic [DATA_WIDTH-1:0]    o_MEM_Data,
    input  logic                     i_MEM_Valid,
    input  logic                     i_MEM_Last,
    input  logic [DATA_WIDTH-1:0]    i_MEM_Data,
    output logic                     o_Busy,
    output logic                     o_Error
);
    localparam int CW = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, GRANT_IC = 2'd1, GRANT_DC = 2'd2} state_t;

    state_t        state, state_nx;
    logic          last_grant, last_grant_nx;
    logic [CW-1:0] beat_count, beat_count_nx;
    logic          gic, gdc, forced;

    assign gic    = (state == GRANT_IC);
    assign gdc    = (state == GRANT_DC);
    assign forced = (gic | gdc) & i_MEM_Valid & ~i_MEM_Last & (beat_count == CW'(BURST_LEN - 1));

    assign o_MEM_Valid    = gic ? i_IC_MEM_Valid : (gdc & i_DC_MEM_Valid);
    assign o_MEM_Write    = gdc & i_DC_MEM_Write;
    assign o_MEM_Address  = gdc ? i_DC_MEM_Address : i_IC_MEM_Address;
    assign o_MEM_Data     = gdc ? i_DC_MEM_Data : '0;
    assign o_IC_MEM_Valid = gic & i_MEM_Valid;
    assign o_IC_MEM_Last  = gic & (i_MEM_Last | forced);
    assign o_DC_MEM_Valid = gdc & i_MEM_Valid;
    assign o_DC_MEM_Last  = gdc & (i_MEM_Last | forced);
    assign o_IC_MEM_Data  = i_MEM_Data;
    assign o_DC_MEM_Data  = i_MEM_Data;
    assign o_Busy         = (state != IDLE);

    // state, round-robin pointer, beat counter and the delayed forced-release pulse
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            beat_count <= '0;
            o_Error    <= 1'b0;
        end else begin
            state      <= state_nx;
            last_grant <= last_grant_nx;
            beat_count <= beat_count_nx;
            o_Error    <= forced;
        end
    end

    // arbitration in IDLE (tie goes to the requester not served last); burst tracking in GRANT
    always_comb begin
        state_nx      = state;
        last_grant_nx = last_grant;
        beat_count_nx = beat_count;
        if (state == IDLE) begin
            beat_count_nx = '0;
            if (i_IC_MEM_Valid && (!i_DC_MEM_Valid || last_grant)) begin
                state_nx      = GRANT_IC;
                last_grant_nx = 1'b0;
            end else if (i_DC_MEM_Valid) begin
                state_nx      = GRANT_DC;
                last_grant_nx = 1'b1;
            end
        end else if (i_MEM_Valid) begin
            beat_count_nx = beat_count + 1'b1;
            if (i_MEM_Last || forced)
                state_nx = IDLE;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter
module tb_mem_arbiter;
    logic        i_Clk = 1'b0;
    logic        i_Reset = 1'b1;
    logic        i_IC_MEM_Valid = 1'b0;
    logic [21:0] i_IC_MEM_Address = '0;
    logic        o_IC_MEM_Valid, o_IC_MEM_Last;
    logic [31:0] o_IC_MEM_Data;
    logic        i_DC_MEM_Valid = 1'b0;
    logic        i_DC_MEM_Write = 1'b0;
    logic [21:0] i_DC_MEM_Address = '0;
    logic [31:0] i_DC_MEM_Data = '0;
    logic        o_DC_MEM_Valid, o_DC_MEM_Last;
    logic [31:0] o_DC_MEM_Data;
    logic        o_MEM_Valid, o_MEM_Write;
    logic [21:0] o_MEM_Address;
    logic [31:0] o_MEM_Data;
    logic        i_MEM_Valid = 1'b0;
    logic        i_MEM_Last = 1'b0;
    logic [31:0] i_MEM_Data = '0;
    logic        o_Busy, o_Error;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        dc;
        logic [31:0] d;
        logic        l;
    } exp_t;
    exp_t q[$];

    mem_arbiter #(.DATA_WIDTH(32), .ADDRESS_WIDTH(22), .BURST_LEN(4)) dut (
        .i_Clk(i_Clk), .i_Reset(i_Reset),
        .i_IC_MEM_Valid(i_IC_MEM_Valid), .i_IC_MEM_Address(i_IC_MEM_Address),
        .o_IC_MEM_Valid(o_IC_MEM_Valid), .o_IC_MEM_Last(o_IC_MEM_Last), .o_IC_MEM_Data(o_IC_MEM_Data),
        .i_DC_MEM_Valid(i_DC_MEM_Valid), .i_DC_MEM_Write(i_DC_MEM_Write),
        .i_DC_MEM_Address(i_DC_MEM_Address), .i_DC_MEM_Data(i_DC_MEM_Data),
        .o_DC_MEM_Valid(o_DC_MEM_Valid), .o_DC_MEM_Last(o_DC_MEM_Last), .o_DC_MEM_Data(o_DC_MEM_Data),
        .o_MEM_Valid(o_MEM_Valid), .o_MEM_Write(o_MEM_Write),
        .o_MEM_Address(o_MEM_Address), .o_MEM_Data(o_MEM_Data),
        .i_MEM_Valid(i_MEM_Valid), .i_MEM_Last(i_MEM_Last), .i_MEM_Data(i_MEM_Data),
        .o_Busy(o_Busy), .o_Error(o_Error)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_Clk);
        #1;
    endtask

    // one memory beat: expectation queued at drive time, compared once the routed beat appears
    task automatic beat(input logic dc, input logic [31:0] d, input logic mlast, input logic exp_last);
        exp_t e;
        i_MEM_Valid = 1'b1;
        i_MEM_Last  = mlast;
        i_MEM_Data  = d;
        q.push_back('{dc: dc, d: d, l: exp_last});
        #1;
        if (o_IC_MEM_Valid || o_DC_MEM_Valid) begin
            e = q.pop_front();
            chk("beat_ic_valid", {31'b0, o_IC_MEM_Valid}, {31'b0, ~e.dc});
            chk("beat_dc_valid", {31'b0, o_DC_MEM_Valid}, {31'b0, e.dc});
            chk("beat_data", e.dc ? o_DC_MEM_Data : o_IC_MEM_Data, e.d);
            chk("beat_last", {31'b0, e.dc ? o_DC_MEM_Last : o_IC_MEM_Last}, {31'b0, e.l});
            chk("beat_other_last", {31'b0, e.dc ? o_IC_MEM_Last : o_DC_MEM_Last}, 32'd0);
        end else begin
            chk("beat_not_routed", 32'd0, 32'd1);
            void'(q.pop_front());
        end
        step();
        i_MEM_Valid = 1'b0;
        i_MEM_Last  = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst_mem_valid", {31'b0, o_MEM_Valid}, 32'd0);
        chk("rst_mem_write", {31'b0, o_MEM_Write}, 32'd0);
        chk("rst_busy", {31'b0, o_Busy}, 32'd0);
        chk("rst_error", {31'b0, o_Error}, 32'd0);
        chk("rst_resp", {28'b0, o_IC_MEM_Valid, o_IC_MEM_Last, o_DC_MEM_Valid, o_DC_MEM_Last}, 32'd0);
        step();
        step();
        i_Reset = 1'b0;
        step();

        // memory beat in IDLE is ignored
        i_MEM_Valid = 1'b1;
        i_MEM_Data  = 32'hDEAD;
        #1;
        chk("idle_beat_ic", {31'b0, o_IC_MEM_Valid}, 32'd0);
        chk("idle_beat_dc", {31'b0, o_DC_MEM_Valid}, 32'd0);
        step();
        i_MEM_Valid = 1'b0;

        // IC only
        i_IC_MEM_Valid   = 1'b1;
        i_IC_MEM_Address = 22'h000100;
        #1;
        chk("ic_pre_grant", {31'b0, o_MEM_Valid}, 32'd0);
        step();
        chk("ic_grant_valid", {31'b0, o_MEM_Valid}, 32'd1);
        chk("ic_grant_addr", {10'b0, o_MEM_Address}, 32'h100);
        chk("ic_grant_write", {31'b0, o_MEM_Write}, 32'd0);
        chk("ic_busy", {31'b0, o_Busy}, 32'd1);
        for (int i = 0; i < 4; i++) beat(1'b0, 32'hA0 + i, i == 3, i == 3);
        i_IC_MEM_Valid = 1'b0;
        #1;
        chk("ic_bubble_valid", {31'b0, o_MEM_Valid}, 32'd0);
        chk("ic_bubble_busy", {31'b0, o_Busy}, 32'd0);
        chk("ic_bubble_resp", {31'b0, o_IC_MEM_Valid}, 32'd0);
        step();

        // simultaneous requests from reset: IC, then DC, then IC again
        i_Reset = 1'b1;
        #1;
        i_Reset = 1'b0;
        step();
        i_IC_MEM_Valid   = 1'b1;
        i_IC_MEM_Address = 22'h000200;
        i_DC_MEM_Valid   = 1'b1;
        i_DC_MEM_Write   = 1'b0;
        i_DC_MEM_Address = 22'h000300;
        step();
        chk("tie1_addr_ic", {10'b0, o_MEM_Address}, 32'h200);
        chk("tie1_write", {31'b0, o_MEM_Write}, 32'd0);
        for (int i = 0; i < 4; i++) beat(1'b0, 32'hB0 + i, i == 3, i == 3);
        #1;
        chk("tie1_bubble", {31'b0, o_MEM_Valid}, 32'd0);
        step();
        chk("tie2_addr_dc", {10'b0, o_MEM_Address}, 32'h300);
        chk("tie2_valid", {31'b0, o_MEM_Valid}, 32'd1);
        for (int i = 0; i < 4; i++) beat(1'b1, 32'hC0 + i, i == 3, i == 3);
        #1;
        chk("tie2_bubble", {31'b0, o_MEM_Valid}, 32'd0);
        step();
        chk("tie3_addr_ic", {10'b0, o_MEM_Address}, 32'h200);
        for (int i = 0; i < 4; i++) beat(1'b0, 32'hD0 + i, i == 3, i == 3);
        i_IC_MEM_Valid = 1'b0;
        i_DC_MEM_Valid = 1'b0;
        step();

        // DC write-back
        i_DC_MEM_Valid   = 1'b1;
        i_DC_MEM_Write   = 1'b1;
        i_DC_MEM_Address = 22'h0003F0;
        step();
        chk("wb_write", {31'b0, o_MEM_Write}, 32'd1);
        chk("wb_addr", {10'b0, o_MEM_Address}, 32'h3F0);
        for (int i = 0; i < 4; i++) begin
            i_DC_MEM_Data = 32'h11 * (i + 1);
            #1;
            chk("wb_data", o_MEM_Data, 32'h11 * (i + 1));
            beat(1'b1, 32'h0, i == 3, i == 3);
        end
        i_DC_MEM_Valid = 1'b0;
        i_DC_MEM_Write = 1'b0;
        #1;
        chk("wb_done_write", {31'b0, o_MEM_Write}, 32'd0);
        step();

        // missing Last: forced release on beat 4
        i_IC_MEM_Valid   = 1'b1;
        i_IC_MEM_Address = 22'h000400;
        step();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("ml_no_error", {31'b0, o_Error}, 32'd0);
            beat(1'b0, 32'hE0 + i, 1'b0, i == 3);
        end
        i_IC_MEM_Valid = 1'b0;
        #1;
        chk("ml_idle", {31'b0, o_Busy}, 32'd0);
        chk("ml_error", {31'b0, o_Error}, 32'd1);
        step();
        chk("ml_error_once", {31'b0, o_Error}, 32'd0);
        step();

        // reset mid-burst
        i_IC_MEM_Valid   = 1'b1;
        i_IC_MEM_Address = 22'h000500;
        step();
        beat(1'b0, 32'hF0, 1'b0, 1'b0);
        i_MEM_Valid = 1'b1;
        i_MEM_Data  = 32'hF1;
        #1;
        i_Reset = 1'b1;
        #1;
        chk("rst_mid_mem_valid", {31'b0, o_MEM_Valid}, 32'd0);
        chk("rst_mid_ic_valid", {31'b0, o_IC_MEM_Valid}, 32'd0);
        chk("rst_mid_busy", {31'b0, o_Busy}, 32'd0);
        step();
        i_MEM_Valid = 1'b0;
        i_Reset     = 1'b0;
        step();
        step();
        chk("rst_regrant_addr", {10'b0, o_MEM_Address}, 32'h500);
        chk("rst_regrant_valid", {31'b0, o_MEM_Valid}, 32'd1);
        for (int i = 0; i < 4; i++) beat(1'b0, 32'h50 + i, 1'b0, i == 3);
        i_IC_MEM_Valid = 1'b0;
        #1;
        chk("rst_regrant_error", {31'b0, o_Error}, 32'd1);
        chk("scoreboard_empty", q.size(), 32'd0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
